// File: rtl/tlc_sensor_if.sv
// tlc_sensor_if: synchronises and debounces the loop detectors, latches FS/HS requests until served, tracks wait time and flags lamp conflicts.
//   CLOCK, RESET (async, active-high)
//   FS_RAW, HS_RAW          raw loop detectors (asynchronous)
//   HGREEN, HLEFT, FLEFT, FRED  observed controller lamps
//   FS, HS                  latched requests to the controller
//   FS_WAIT, HS_WAIT        saturating pending-cycle counts
//   FS_OVERDUE, HS_OVERDUE  wait count has reached MAX_WAIT
//   CONFLICT                sticky incompatible-lamp fault
module tlc_sensor_if #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WAIT_W          = 8,
  parameter int MAX_WAIT        = 200
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              FS_RAW,
  input  logic              HS_RAW,
  input  logic              HGREEN,
  input  logic              HLEFT,
  input  logic              FLEFT,
  input  logic              FRED,
  output logic              FS,
  output logic              HS,
  output logic [WAIT_W-1:0] FS_WAIT,
  output logic [WAIT_W-1:0] HS_WAIT,
  output logic              FS_OVERDUE,
  output logic              HS_OVERDUE,
  output logic              CONFLICT
);
  localparam logic [3:0] DB = 4'(DEBOUNCE_CYCLES);
  localparam logic [WAIT_W-1:0] MW = WAIT_W'(MAX_WAIT);
  logic [1:0] raw, svc, s1, s2, deb, req;
  logic [3:0] cnt [2];
  logic [3:0] cnt_nx [2];
  logic [WAIT_W-1:0] wt [2];
  logic conflict_now;
  // channel 0 is the side road (FS), channel 1 the highway left turn (HS)
  assign raw = {HS_RAW, FS_RAW};
  assign svc = {HLEFT, FLEFT};
  assign conflict_now = ((HGREEN | HLEFT) & FLEFT) | (FLEFT & FRED);
  always_comb begin
    for (int i = 0; i < 2; i++)
      cnt_nx[i] = !s2[i] ? 4'd0 : (cnt[i] == DB) ? cnt[i] : cnt[i] + 4'd1;
  end
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      s1       <= '0;
      s2       <= '0;
      deb      <= '0;
      req      <= '0;
      CONFLICT <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
        wt[i]  <= '0;
      end
    end else begin
      s1       <= raw;
      s2       <= s1;
      CONFLICT <= CONFLICT | conflict_now;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= cnt_nx[i];
        // presence qualifies on reaching the threshold, drops at once on release
        deb[i] <= s2[i] & (deb[i] | (cnt_nx[i] == DB));
        // service clear wins over a still-present vehicle
        req[i] <= svc[i] ? 1'b0 : deb[i] ? 1'b1 : req[i];
        wt[i]  <= (!req[i] || svc[i]) ? '0 : (&wt[i]) ? wt[i] : wt[i] + 1'b1;
      end
    end
  end
  assign FS         = req[0];
  assign HS         = req[1];
  assign FS_WAIT    = wt[0];
  assign HS_WAIT    = wt[1];
  assign FS_OVERDUE = wt[0] >= MW;
  assign HS_OVERDUE = wt[1] >= MW;
endmodule

// File: tb/tb_tlc_sensor_if.sv
// tb_tlc_sensor_if: directed scoreboard bench for tlc_sensor_if with default parameters.
module tb_tlc_sensor_if;
  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  logic FS_RAW = 1'b0, HS_RAW = 1'b0;
  logic HGREEN = 1'b0, HLEFT = 1'b0, FLEFT = 1'b0, FRED = 1'b0;
  logic FS, HS, FS_OVERDUE, HS_OVERDUE, CONFLICT;
  logic [7:0] FS_WAIT, HS_WAIT;
  int n_assert = 0;
  int n_fail = 0;
  typedef struct {
    string      tag;
    logic [20:0] v;
  } exp_t;
  exp_t sb [$];
  tlc_sensor_if dut (
    .CLOCK(CLOCK), .RESET(RESET), .FS_RAW(FS_RAW), .HS_RAW(HS_RAW),
    .HGREEN(HGREEN), .HLEFT(HLEFT), .FLEFT(FLEFT), .FRED(FRED),
    .FS(FS), .HS(HS), .FS_WAIT(FS_WAIT), .HS_WAIT(HS_WAIT),
    .FS_OVERDUE(FS_OVERDUE), .HS_OVERDUE(HS_OVERDUE), .CONFLICT(CONFLICT)
  );
  always #5 CLOCK = ~CLOCK;
  function automatic logic [20:0] ev(logic fs, logic hs, logic fo, logic ho, logic cf,
                                     logic [7:0] fw, logic [7:0] hw);
    return {fs, hs, fo, ho, cf, fw, hw};
  endfunction
  task automatic push(input string tag, input logic [20:0] v);
    exp_t e;
    e.tag = tag;
    e.v = v;
    sb.push_back(e);
  endtask
  task automatic chk();
    exp_t e;
    logic [20:0] obs;
    e = sb.pop_front();
    obs = {FS, HS, FS_OVERDUE, HS_OVERDUE, CONFLICT, FS_WAIT, HS_WAIT};
    n_assert++;
    assert (obs === e.v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask
  task automatic step(input string tag, input logic [20:0] v);
    push(tag, v);
    tick(1);
    chk();
  endtask
  task automatic do_reset();
    #2 RESET = 1'b1;
    #1;
    push("reset_async", ev(0, 0, 0, 0, 0, 0, 0));
    chk();
    tick(1);
    push("reset_held", ev(0, 0, 0, 0, 0, 0, 0));
    chk();
    RESET = 1'b0;
  endtask
  initial begin
    tick(2);
    push("reset_state", ev(0, 0, 0, 0, 0, 0, 0));
    chk();
    RESET = 1'b0;
    // FS latency from first sampling edge
    FS_RAW = 1'b1;
    for (int i = 1; i <= 6; i++) step("t1_pre", ev(0, 0, 0, 0, 0, 0, 0));
    step("t1_set_e7", ev(1, 0, 0, 0, 0, 0, 0));
    step("t1_wait1_e8", ev(1, 0, 0, 0, 0, 1, 0));
    FS_RAW = 1'b0;
    do_reset();
    // HS glitch of three cycles is rejected
    HS_RAW = 1'b1;
    for (int i = 0; i < 3; i++) step("t2_glitch_hi", ev(0, 0, 0, 0, 0, 0, 0));
    HS_RAW = 1'b0;
    for (int i = 0; i < 8; i++) step("t2_glitch_lo", ev(0, 0, 0, 0, 0, 0, 0));
    do_reset();
    // HS service clears latch and wait, re-sets once service ends
    HS_RAW = 1'b1;
    tick(6);
    step("t3_set_e7", ev(0, 1, 0, 0, 0, 0, 0));
    step("t3_w1", ev(0, 1, 0, 0, 0, 0, 1));
    step("t3_w2", ev(0, 1, 0, 0, 0, 0, 2));
    HLEFT = 1'b1;
    step("t3_served1", ev(0, 0, 0, 0, 0, 0, 0));
    step("t3_served2", ev(0, 0, 0, 0, 0, 0, 0));
    HLEFT = 1'b0;
    step("t3_reset_req", ev(0, 1, 0, 0, 0, 0, 0));
    step("t3_rewait1", ev(0, 1, 0, 0, 0, 0, 1));
    HS_RAW = 1'b0;
    do_reset();
    // FS overdue threshold and saturation
    FS_RAW = 1'b1;
    tick(7);
    push("t4_latched", ev(1, 0, 0, 0, 0, 0, 0));
    chk();
    tick(198);
    step("t4_w199", ev(1, 0, 0, 0, 0, 199, 0));
    step("t4_w200", ev(1, 0, 1, 0, 0, 200, 0));
    tick(54);
    step("t4_w255", ev(1, 0, 1, 0, 0, 255, 0));
    step("t4_sat", ev(1, 0, 1, 0, 0, 255, 0));
    FS_RAW = 1'b0;
    do_reset();
    // conflict monitor
    HGREEN = 1'b1; HLEFT = 1'b1; FRED = 1'b1;
    step("t5_no_conflict", ev(0, 0, 0, 0, 0, 0, 0));
    HLEFT = 1'b0; FRED = 1'b0; FLEFT = 1'b1;
    step("t5_hg_fl", ev(0, 0, 0, 0, 1, 0, 0));
    HGREEN = 1'b0; FLEFT = 1'b0;
    step("t5_sticky1", ev(0, 0, 0, 0, 1, 0, 0));
    step("t5_sticky2", ev(0, 0, 0, 0, 1, 0, 0));
    do_reset();
    step("t5_cleared", ev(0, 0, 0, 0, 0, 0, 0));
    FLEFT = 1'b1; FRED = 1'b1;
    step("t5_fl_fr", ev(0, 0, 0, 0, 1, 0, 0));
    FLEFT = 1'b0; FRED = 1'b0;
    do_reset();
    // reset mid-operation with the vehicle still present
    FS_RAW = 1'b1;
    tick(56);
    step("t6_w50", ev(1, 0, 0, 0, 0, 50, 0));
    do_reset();
    for (int i = 1; i <= 6; i++) step("t6_pre", ev(0, 0, 0, 0, 0, 0, 0));
    step("t6_set_e7", ev(1, 0, 0, 0, 0, 0, 0));
    step("t6_wait1", ev(1, 0, 0, 0, 0, 1, 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
